// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the shared 1M x 16 SRAM: video-first with a CPU starvation guard,
// fixed-length strobed access driven by a wait counter, one-cycle completion pulse per access.
module sram_arbiter #(
    parameter int WAIT_CYCLES   = 2,
    parameter int MAX_VID_BURST = 4
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        Cpu_Req,
    input  logic        Cpu_R_W,
    input  logic [15:0] Cpu_Addr,
    input  logic [15:0] Cpu_WData,
    output logic [15:0] Cpu_RData,
    output logic        Cpu_Ready,
    input  logic        Vid_Req,
    input  logic [19:0] Vid_Addr,
    output logic [15:0] Vid_RData,
    output logic        Vid_Valid,
    output logic        Mem_CE,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [19:0] Mem_Addr,
    output logic [15:0] Mem_WData,
    input  logic [15:0] Mem_RData
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int VC_W  = $clog2(MAX_VID_BURST + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [VC_W-1:0]  VID_MAX   = VC_W'(MAX_VID_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [VC_W-1:0]   vid_cnt_q, vid_cnt_d;
    logic              owner_vid_q, owner_vid_d;
    logic              wr_q, wr_d;
    logic [19:0]       mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_oe_q, mem_oe_d;
    logic              mem_we_q, mem_we_d;
    logic [15:0]       cpu_rdata_q, cpu_rdata_d;
    logic [15:0]       vid_rdata_q, vid_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              vid_valid_q, vid_valid_d;

    logic cpu_grant;
    logic vid_grant;
    logic grant_wr;

    // CPU only overtakes a pending video request once the burst allowance is used up.
    assign cpu_grant = (state_q == IDLE) && Cpu_Req && (!Vid_Req || (vid_cnt_q == VID_MAX));
    assign vid_grant = (state_q == IDLE) && Vid_Req && !cpu_grant;
    assign grant_wr  = cpu_grant && Cpu_R_W;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_grant || vid_grant) state_d = ACCESS;
            ACCESS:  if (wait_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_d      = wait_q;
        vid_cnt_d   = vid_cnt_q;
        owner_vid_d = owner_vid_q;
        wr_d        = wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        mem_ce_d    = 1'b0;
        mem_oe_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_ready_d = 1'b0;
        vid_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_grant || vid_grant) begin
                    owner_vid_d = vid_grant;
                    wr_d        = grant_wr;
                    mem_addr_d  = cpu_grant ? {4'b0000, Cpu_Addr} : Vid_Addr;
                    mem_wdata_d = Cpu_WData;
                    wait_d      = WAIT_LOAD;
                    mem_ce_d    = 1'b1;
                    mem_oe_d    = !grant_wr;
                    mem_we_d    = grant_wr;
                    if (cpu_grant) begin
                        vid_cnt_d = '0;
                    end else if (vid_cnt_q != VID_MAX) begin
                        vid_cnt_d = vid_cnt_q + 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (wait_q == '0) begin
                    // Last strobe cycle: sample the SRAM and raise the owner's pulse.
                    if (!wr_q) begin
                        if (owner_vid_q) vid_rdata_d = Mem_RData;
                        else             cpu_rdata_d = Mem_RData;
                    end
                    cpu_ready_d = !owner_vid_q;
                    vid_valid_d = owner_vid_q;
                end else begin
                    wait_d   = wait_q - 1'b1;
                    mem_ce_d = 1'b1;
                    mem_oe_d = !wr_q;
                    mem_we_d = wr_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wait_q      <= '0;
            vid_cnt_q   <= '0;
            owner_vid_q <= 1'b0;
            wr_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ce_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            vid_valid_q <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            vid_cnt_q   <= vid_cnt_d;
            owner_vid_q <= owner_vid_d;
            wr_q        <= wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ce_q    <= mem_ce_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_q    <= mem_we_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            vid_valid_q <= vid_valid_d;
        end
    end

    assign Mem_CE    = mem_ce_q;
    assign Mem_OE    = mem_oe_q;
    assign Mem_WE    = mem_we_q;
    assign Mem_Addr  = mem_addr_q;
    assign Mem_WData = mem_wdata_q;
    assign Cpu_RData = cpu_rdata_q;
    assign Cpu_Ready = cpu_ready_q;
    assign Vid_RData = vid_rdata_q;
    assign Vid_Valid = vid_valid_q;

    a_no_oe_we: assert property (@(posedge Clk) disable iff (!Reset_N) !(Mem_OE && Mem_WE));
    a_ce_cover: assert property (@(posedge Clk) disable iff (!Reset_N) (Mem_OE || Mem_WE) |-> Mem_CE);
    a_one_pulse: assert property (@(posedge Clk) disable iff (!Reset_N) !(Cpu_Ready && Vid_Valid));

endmodule
